// File: rtl/gemm_cmd_scheduler.sv
// GEMM command scheduler: queues core-issued GEMM commands and hands them one at a
// time to the accelerator's start/ready/done handshake, with a run watchdog.
module gemm_cmd_scheduler #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned DW      = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       gemm_valid,
   input  logic [DW-1:0]              gemm_rdata1,
   input  logic [DW-1:0]              gemm_rdata2,
   output logic                       cmd_accept,
   output logic                       gemm_done,
   output logic                       acc_start,
   output logic [DW-1:0]              acc_src,
   output logic [DW-1:0]              acc_cfg,
   input  logic                       acc_ready,
   input  logic                       acc_done,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     pending,
   output logic                       err_timeout,
   input  logic                       err_clr
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned WDW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WDW-1:0]   watchdog_q, watchdog_d;
   logic             errTimeout_q, errTimeout_d;
   logic             accStart_q, accStart_d;
   logic [DW-1:0]    accSrc_q, accSrc_d;
   logic [DW-1:0]    accCfg_q, accCfg_d;
   logic             gemmDone_q, gemmDone_d;

   logic [DW-1:0]    memSrc [DEPTH];
   logic [DW-1:0]    memCfg [DEPTH];

   logic             fifoFull;
   logic             fifoEmpty;
   logic             push;
   logic             pop;
   logic             timeoutHit;

   assign fifoFull  = (count_q == CW'(DEPTH));
   assign fifoEmpty = (count_q == '0);
   assign push      = gemm_valid && !fifoFull;
   assign pop       = (state_q == ISSUE) && acc_ready;

   // Storage carries no reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         memSrc[wrPtr_q] <= gemm_rdata1;
         memCfg[wrPtr_q] <= gemm_rdata2;
      end
   end

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) begin
         wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      timeoutHit = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifoEmpty) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (acc_ready) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // A real completion on the final watchdog cycle is not an error.
            if (acc_done) begin
               state_d = DONE;
            end else if (watchdog_q == WDW'(TIMEOUT - 1)) begin
               state_d    = DONE;
               timeoutHit = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      watchdog_d = watchdog_q;
      if (pop) begin
         watchdog_d = '0;
      end else if (state_q == RUN) begin
         watchdog_d = watchdog_q + WDW'(1);
      end

      errTimeout_d = errTimeout_q;
      if (timeoutHit) begin
         errTimeout_d = 1'b1;
      end else if (err_clr) begin
         errTimeout_d = 1'b0;
      end

      // Operands are captured on entry to ISSUE and held until the handoff.
      accStart_d = (state_d == ISSUE);
      accSrc_d   = '0;
      accCfg_d   = '0;
      if (state_d == ISSUE) begin
         if (state_q == ISSUE) begin
            accSrc_d = accSrc_q;
            accCfg_d = accCfg_q;
         end else begin
            accSrc_d = memSrc[rdPtr_q];
            accCfg_d = memCfg[rdPtr_q];
         end
      end

      gemmDone_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         count_q      <= '0;
         watchdog_q   <= '0;
         errTimeout_q <= 1'b0;
         accStart_q   <= 1'b0;
         accSrc_q     <= '0;
         accCfg_q     <= '0;
         gemmDone_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wrPtr_q      <= wrPtr_d;
         rdPtr_q      <= rdPtr_d;
         count_q      <= count_d;
         watchdog_q   <= watchdog_d;
         errTimeout_q <= errTimeout_d;
         accStart_q   <= accStart_d;
         accSrc_q     <= accSrc_d;
         accCfg_q     <= accCfg_d;
         gemmDone_q   <= gemmDone_d;
      end
   end

   assign cmd_accept  = !fifoFull;
   assign gemm_done   = gemmDone_q;
   assign acc_start   = accStart_q;
   assign acc_src     = accSrc_q;
   assign acc_cfg     = accCfg_q;
   assign busy        = (state_q != IDLE) || !fifoEmpty;
   assign pending     = count_q;
   assign err_timeout = errTimeout_q;

endmodule
